prog_xbar_cfg: RTL and testbench

Programmable OUTPUTS-by-INPUTS routing crossbar for the FPGA fabric, configured over the standard serial programming chain. It generalises the single programmable mux to several outputs. Configuration is double-buffered: a shadow chain shifts while the active configuration keeps routing. A bit counter gates a commit strobe that copies shadow to active, and each output carries a per-output registered/combinational mode bit.

---
 rtl/prog_xbar_cfg_pkg.sv | 38 +++
 rtl/prog_xbar_cfg_if.sv | 31 +++
 rtl/prog_cfg_chain.sv | 43 ++++
 rtl/prog_mux.sv | 26 ++
 rtl/prog_xbar_cfg.sv | 91 +++++++++
 tb/tb_prog_xbar_cfg.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/prog_xbar_cfg_pkg.sv
// Shared programming constants and helpers for the programmable crossbar.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
// Field layout: each output owns W = SEL+1 chain bits; select in [SEL-1:0],
// mode (1 = registered) at bit offset SEL within the field.
package prog_xbar_cfg_pkg;

  typedef enum logic [1:0] {
    CMT_IDLE   = 2'd0,
    CMT_ACCEPT = 2'd1,
    CMT_REJECT = 2'd2
  } commit_e;

  // Bits per output field: select plus one mode bit.
  function automatic int field_w(input int sel);
    return sel + 1;
  endfunction

  // Offset of the mode bit inside a field (the field MSB).
  function automatic int mode_bit(input int sel);
    return sel;
  endfunction

  function automatic int chain_len(input int sel, input int outputs);
    return outputs * field_w(sel);
  endfunction

  // A commit is honoured only when the shadow is exactly full and no shift
  // is happening in the same cycle; anything else is flagged as an error.
  function automatic commit_e commit_decide(input logic commit,
                                            input logic prog_en,
                                            input logic prog_done);
    if (!commit) return CMT_IDLE;
    if (!prog_en && prog_done) return CMT_ACCEPT;
    return CMT_REJECT;
  endfunction

endpackage

// File: rtl/prog_xbar_cfg_if.sv
// Fabric-side and programming-side signal bundle of the crossbar.
// Latency: none (wires only).
// Backpressure: none; the programming chain is free-running under prog_en.
// Ports: in/out routed data, prog_in/prog_en/commit chain control,
// prog_out/prog_done/cfg_valid/cfg_err chain status.
interface prog_xbar_cfg_if #(
  parameter int INPUTS  = 16,
  parameter int OUTPUTS = 4
) ();

  logic [INPUTS-1:0]  in;
  logic [OUTPUTS-1:0] out;
  logic               prog_in;
  logic               prog_en;
  logic               commit;
  logic               prog_out;
  logic               prog_done;
  logic               cfg_valid;
  logic               cfg_err;

  modport master (
    output in, prog_in, prog_en, commit,
    input  out, prog_out, prog_done, cfg_valid, cfg_err
  );

  modport slave (
    input  in, prog_in, prog_en, commit,
    output out, prog_out, prog_done, cfg_valid, cfg_err
  );

endinterface

// File: rtl/prog_cfg_chain.sv
// Shadow configuration shift chain with saturating bit counter.
// Latency: prog_out and prog_done update one edge after each shift.
// Backpressure: none; shifts every cycle prog_en is high.
// Ports: prog_clk/prog_rst, prog_in/shift_en serial input, clear (accepted
// commit), shadow (parallel contents), prog_out (chain MSB), prog_done.
module prog_cfg_chain #(
  parameter int CHAIN = 20
) (
  input  logic             prog_clk,
  input  logic             prog_rst,
  input  logic             prog_in,
  input  logic             shift_en,
  input  logic             clear,
  output logic [CHAIN-1:0] shadow,
  output logic             prog_out,
  output logic             prog_done
);

  localparam int CW = $clog2(CHAIN + 1);

  logic [CW-1:0] count;

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      shadow <= '0;
      count  <= '0;
    end else if (shift_en) begin
      // First bit in ends at the MSB after CHAIN shifts.
      shadow <= {shadow[CHAIN-2:0], prog_in};
      // Saturate so overshifting still reports a full chain.
      if (count != CW'(CHAIN)) begin
        count <= count + CW'(1);
      end
    end else if (clear) begin
      count <= '0;
    end
  end

  // Shadow MSB is itself a flop, so the daisy-chain output is registered.
  assign prog_out  = shadow[CHAIN-1];
  assign prog_done = (count == CW'(CHAIN));

endmodule

// File: rtl/prog_mux.sv
// Parametrised routing mux: picks in[sel], zero when sel addresses no input.
// Latency: combinational.
// Backpressure: none.
// Ports: in (INPUTS wide), sel (SEL wide), out (1 bit).
module prog_mux #(
  parameter int SEL    = 4,
  parameter int INPUTS = 16
) (
  input  logic [INPUTS-1:0] in,
  input  logic [SEL-1:0]    sel,
  output logic              out
);

  // Zero-extend to the full select space so unused codes read as 0.
  logic [(2**SEL)-1:0] in_ext;

  always_comb begin
    in_ext = '0;
    for (int i = 0; i < INPUTS; i++) begin
      in_ext[i] = in[i];
    end
  end

  assign out = in_ext[sel];

endmodule

// File: rtl/prog_xbar_cfg.sv
// OUTPUTS-by-INPUTS programmable crossbar with double-buffered serial config.
// Latency: comb-mode outputs 0 cycles; reg-mode outputs 1 cycle; new config
// takes effect the edge after an accepted commit.
// Backpressure: none; rejected commits are dropped and flagged on cfg_err.
// Ports: prog_clk, prog_rst (sync, active high), bus (slave modport).
module prog_xbar_cfg
  import prog_xbar_cfg_pkg::*;
#(
  parameter int SEL     = 4,
  parameter int INPUTS  = 16,
  parameter int OUTPUTS = 4
) (
  input logic            prog_clk,
  input logic            prog_rst,
  prog_xbar_cfg_if.slave bus
);

  localparam int W     = field_w(SEL);
  localparam int CHAIN = chain_len(SEL, OUTPUTS);
  localparam int MODE  = mode_bit(SEL);

  logic [CHAIN-1:0]   shadow;
  logic [CHAIN-1:0]   active;
  logic               prog_done;
  commit_e            cmt;
  logic [OUTPUTS-1:0] raw;
  logic [OUTPUTS-1:0] mode;
  logic [OUTPUTS-1:0] out_q;
  logic [OUTPUTS-1:0] routed;
  logic               cfg_valid;
  logic               cfg_err;

  assign cmt = commit_decide(bus.commit, bus.prog_en, prog_done);

  prog_cfg_chain #(
    .CHAIN (CHAIN)
  ) u_chain (
    .prog_clk  (prog_clk),
    .prog_rst  (prog_rst),
    .prog_in   (bus.prog_in),
    .shift_en  (bus.prog_en),
    .clear     (cmt == CMT_ACCEPT),
    .shadow    (shadow),
    .prog_out  (bus.prog_out),
    .prog_done (prog_done)
  );

  for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
    prog_mux #(
      .SEL    (SEL),
      .INPUTS (INPUTS)
    ) u_mux (
      .in  (bus.in),
      .sel (active[k*W +: SEL]),
      .out (raw[k])
    );
    assign mode[k] = active[k*W + MODE];
  end

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      active    <= '0;
      out_q     <= '0;
      cfg_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      // Flops always track raw under the current active config, so a
      // freshly committed registered field shows its input one edge later.
      out_q   <= raw;
      cfg_err <= (cmt == CMT_REJECT);
      if (cmt == CMT_ACCEPT) begin
        active    <= shadow;
        cfg_valid <= 1'b1;
      end
    end
  end

  // Mode selects per output, so a 1->0 mode change hides the stale flop.
  always_comb begin
    routed = '0;
    for (int k = 0; k < OUTPUTS; k++) begin
      routed[k] = mode[k] ? out_q[k] : raw[k];
    end
  end

  assign bus.out       = cfg_valid ? routed : '0;
  assign bus.prog_done = prog_done;
  assign bus.cfg_valid = cfg_valid;
  assign bus.cfg_err   = cfg_err;

endmodule

// File: tb/tb_prog_xbar_cfg.sv
// Bench for prog_xbar_cfg: default instance (SEL=4, INPUTS=16) and a wide
// instance (SEL=5, INPUTS=20) against a field-level reference model.
// Directed scenarios first, then randomized shifting/committing/resets.
module tb_prog_xbar_cfg;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic rst_a, rst_b;

  prog_xbar_cfg_if #(.INPUTS(16), .OUTPUTS(4)) a_if ();
  prog_xbar_cfg_if #(.INPUTS(20), .OUTPUTS(4)) b_if ();

  prog_xbar_cfg #(.SEL(4), .INPUTS(16), .OUTPUTS(4)) dut_a (
    .prog_clk (prog_clk),
    .prog_rst (rst_a),
    .bus      (a_if.slave)
  );

  prog_xbar_cfg #(.SEL(5), .INPUTS(20), .OUTPUTS(4)) dut_b (
    .prog_clk (prog_clk),
    .prog_rst (rst_b),
    .bus      (b_if.slave)
  );

  // Stimulus per instance (index 0 = a, 1 = b).
  bit          rst_v [2];
  bit          pen_v [2];
  bit          pin_v [2];
  bit          cmt_v [2];
  logic [31:0] in_v  [2];

  // Reference model: decoded active fields plus the last shifted bits.
  bit hist  [2][32];   // hist[d][j] = j-th most recently shifted bit
  int cnt   [2];
  bit vld   [2];
  bit err   [2];
  int asel  [2][4];
  bit amode [2][4];
  bit flop  [2][4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int selw(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic int n_inputs(input int d);
    return (d == 0) ? 16 : 20;
  endfunction

  function automatic int n_chain(input int d);
    return 4 * (selw(d) + 1);
  endfunction

  function automatic bit raw_m(input int d, input int k, input logic [31:0] iv);
    int s;
    s = asel[d][k];
    if (s < n_inputs(d)) return iv[s];
    return 1'b0;
  endfunction

  task automatic model_edge(input int d);
    bit acc;
    int w;
    int s;
    if (rst_v[d]) begin
      for (int j = 0; j < 32; j++) hist[d][j] = 1'b0;
      cnt[d] = 0;
      vld[d] = 1'b0;
      err[d] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        asel[d][k]  = 0;
        amode[d][k] = 1'b0;
        flop[d][k]  = 1'b0;
      end
    end else begin
      acc = cmt_v[d] && !pen_v[d] && (cnt[d] == n_chain(d));
      for (int k = 0; k < 4; k++) flop[d][k] = raw_m(d, k, in_v[d]);
      err[d] = cmt_v[d] && !acc;
      if (pen_v[d]) begin
        for (int j = 31; j > 0; j--) hist[d][j] = hist[d][j-1];
        hist[d][0] = pin_v[d];
        if (cnt[d] < n_chain(d)) cnt[d]++;
      end else if (acc) begin
        w = selw(d) + 1;
        for (int k = 0; k < 4; k++) begin
          s = 0;
          for (int b = 0; b < selw(d); b++) begin
            if (hist[d][k*w + b]) s += (1 << b);
          end
          asel[d][k]  = s;
          amode[d][k] = hist[d][k*w + w - 1];
        end
        cnt[d] = 0;
        vld[d] = 1'b1;
      end
    end
  endtask

  task automatic check_d(input int d);
    logic [3:0] o, e;
    logic po, pd, cv, ce;
    string p;
    if (d == 0) begin
      o = a_if.out; po = a_if.prog_out; pd = a_if.prog_done;
      cv = a_if.cfg_valid; ce = a_if.cfg_err; p = "a";
    end else begin
      o = b_if.out; po = b_if.prog_out; pd = b_if.prog_done;
      cv = b_if.cfg_valid; ce = b_if.cfg_err; p = "b";
    end
    for (int k = 0; k < 4; k++) begin
      e[k] = vld[d] ? (amode[d][k] ? flop[d][k] : raw_m(d, k, in_v[d])) : 1'b0;
    end
    chk({p, "_out"}, 32'(o), 32'(e));
    chk({p, "_prog_out"}, 32'(po), 32'(hist[d][n_chain(d)-1]));
    chk({p, "_prog_done"}, 32'(pd), 32'(cnt[d] == n_chain(d)));
    chk({p, "_cfg_valid"}, 32'(cv), 32'(vld[d]));
    chk({p, "_cfg_err"}, 32'(ce), 32'(err[d]));
  endtask

  // One clock: drive, let the edge happen, advance model, check mid-cycle.
  task automatic tick();
    rst_a        = rst_v[0];
    rst_b        = rst_v[1];
    a_if.in      = in_v[0][15:0];
    a_if.prog_in = pin_v[0];
    a_if.prog_en = pen_v[0];
    a_if.commit  = cmt_v[0];
    b_if.in      = in_v[1][19:0];
    b_if.prog_in = pin_v[1];
    b_if.prog_en = pen_v[1];
    b_if.commit  = cmt_v[1];
    @(posedge prog_clk);
    model_edge(0);
    model_edge(1);
    @(negedge prog_clk);
    check_d(0);
    check_d(1);
  endtask

  // Shift the low n bits of val, MSB first.
  task automatic shift_bits(input int d, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      pin_v[d] = val[i];
      pen_v[d] = 1'b1;
      tick();
    end
    pen_v[d] = 1'b0;
  endtask

  task automatic do_commit(input int d);
    cmt_v[d] = 1'b1;
    tick();
    cmt_v[d] = 1'b0;
  endtask

  task automatic do_reset(input int d);
    rst_v[d] = 1'b1;
    tick();
    rst_v[d] = 1'b0;
  endtask

  logic [31:0] pat_a;
  logic [31:0] pat_b;
  logic [31:0] rnd;

  initial begin
    pat_a = 32'({5'b0_0011, 5'b1_0111, 5'b0_1111, 5'b0_0000});
    pat_b = 32'({6'b0_11001, 6'b0_10011, 6'b1_00100, 6'b0_00000});
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1; pen_v[d] = 1'b0; pin_v[d] = 1'b0;
      cmt_v[d] = 1'b0; in_v[d] = '0;
    end
    tick();
    tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    chk("rst_out", 32'(a_if.out), 32'h0);
    chk("rst_prog_done", 32'(a_if.prog_done), 32'h0);
    chk("rst_cfg_valid", 32'(a_if.cfg_valid), 32'h0);

    // Basic routing: f3 comb in[3], f2 reg in[7], f1 in[15], f0 in[0].
    in_v[0] = 32'h0088;
    shift_bits(0, pat_a, 20);
    chk("basic_done", 32'(a_if.prog_done), 32'h1);
    do_commit(0);
    chk("basic_valid", 32'(a_if.cfg_valid), 32'h1);
    chk("basic_out3", 32'(a_if.out[3]), 32'h1);
    chk("basic_out1", 32'(a_if.out[1]), 32'h0);
    chk("basic_out0", 32'(a_if.out[0]), 32'h0);
    chk("basic_done_clr", 32'(a_if.prog_done), 32'h0);
    tick();
    chk("basic_out2_reg", 32'(a_if.out[2]), 32'h1);

    // New pattern shifts in behind the live config; old shadow replays out.
    for (int i = 0; i < 20; i++) begin
      pin_v[0] = 1'($urandom);
      pen_v[0] = 1'b1;
      tick();
      if (i < 19) chk("replay_prog_out", 32'(a_if.prog_out), 32'(pat_a[18-i]));
      chk("replay_hold_out", 32'(a_if.out), 32'hC);
    end
    pen_v[0] = 1'b0;
    do_commit(0);
    tick();

    // Short chain: commit rejected, one more bit makes it acceptable.
    do_reset(0);
    shift_bits(0, $urandom, 19);
    do_commit(0);
    chk("short_err", 32'(a_if.cfg_err), 32'h1);
    chk("short_valid", 32'(a_if.cfg_valid), 32'h0);
    chk("short_out", 32'(a_if.out), 32'h0);
    tick();
    chk("short_err_pulse", 32'(a_if.cfg_err), 32'h0);
    shift_bits(0, $urandom, 1);
    chk("short_done", 32'(a_if.prog_done), 32'h1);
    do_commit(0);
    chk("short_accept", 32'(a_if.cfg_valid), 32'h1);

    // Commit together with the final shift is rejected, next one accepted.
    do_reset(0);
    in_v[0] = 32'h0088;
    shift_bits(0, pat_a >> 1, 19);
    pin_v[0] = pat_a[0];
    pen_v[0] = 1'b1;
    cmt_v[0] = 1'b1;
    tick();
    pen_v[0] = 1'b0;
    chk("overlap_err", 32'(a_if.cfg_err), 32'h1);
    chk("overlap_done", 32'(a_if.prog_done), 32'h1);
    chk("overlap_valid", 32'(a_if.cfg_valid), 32'h0);
    tick();
    cmt_v[0] = 1'b0;
    chk("overlap_accept", 32'(a_if.cfg_valid), 32'h1);
    tick();
    chk("overlap_route", 32'(a_if.out), 32'hC);

    // Wide instance: select 25 exceeds INPUTS and must read 0.
    in_v[1] = 32'h000F_FFFE;
    shift_bits(1, pat_b, 24);
    do_commit(1);
    chk("wide_out_commit", 32'(b_if.out), 32'h4);
    tick();
    chk("wide_out_reg", 32'(b_if.out), 32'h6);
    chk("wide_sel25", 32'(b_if.out[3]), 32'h0);

    // Reset in the middle of a reload, then reload and commit.
    shift_bits(0, $urandom, 10);
    do_reset(0);
    chk("midrst_done", 32'(a_if.prog_done), 32'h0);
    chk("midrst_out", 32'(a_if.out), 32'h0);
    chk("midrst_valid", 32'(a_if.cfg_valid), 32'h0);
    chk("midrst_prog_out", 32'(a_if.prog_out), 32'h0);
    shift_bits(0, pat_a, 20);
    do_commit(0);
    tick();
    chk("midrst_restore", 32'(a_if.out), 32'hC);

    // Random traffic on both instances against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        rnd      = $urandom;
        rst_v[d] = (rnd[7:0] == 8'd0);
        pen_v[d] = (rnd[11:8] < 4'd11);
        pin_v[d] = rnd[12];
        cmt_v[d] = (rnd[15:13] == 3'd0);
        in_v[d]  = $urandom;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
